edge_fb_ctrl: RTL and testbench
===============================

Name: edge_fb_ctrl

Overview:
- Double-buffered 1-bit edge-bitmap frame store and sequencer between the edge-detector output stream (writer) and the VGA scan logic (reader).
- Writer fills the back buffer in raster order over a valid/ready handshake.
- Reader gets a registered pixel for each scan coordinate.
- Buffers swap only at a display frame boundary, so the screen never shows a partially written frame.

Parameters:
- WIDTH, 9, pixels per line of the bitmap.
- DEPTH, 9, lines per frame.
- NPIX, WIDTH*DEPTH, pixels per frame (derived, not overridden).
- AW, 7, address width; must satisfy 2^AW >= NPIX.

Ports:
- dclk  input  1  pixel clock.
- clr  input  1  reset.
- wr_valid  input  1  writer has a pixel.
- wr_ready  output  1  block accepts pixel this cycle.
- wr_pixel  input  1  edge bit (1 = edge).
- wr_sof  input  1  start of frame, qualifies the accepted beat.
- scan_x  input  10  display column of the current pixel.
- scan_y  input  10  display line of the current pixel.
- pix_out  output  1  registered bitmap pixel for the scan position.
- swap_pulse  output  1  one-cycle pulse on the edge the buffers swap.
- fill_state  output  1  0 = FILL, 1 = PENDING.
- repeat_cnt  output  8  saturating count of frames re-shown because no new frame was ready.

Interface (already decided): reset clr, asynchronous, active-high; clock dclk.

Behaviour:
- Reset (clr=1, asynchronous, active-high):
  - Both buffers cleared to 0; front select = buffer 0.
  - State FILL, wr_addr = 0.
  - wr_ready = 1 after reset deasserts; pix_out = 0, swap_pulse = 0, repeat_cnt = 0.
- Beat accepted = wr_valid & wr_ready on a rising dclk.
- State FILL (wr_ready = 1):
  - Each accepted beat writes wr_pixel to back[addr].
  - addr = 0 if wr_sof = 1, else wr_addr. Then wr_addr <= addr + 1.
  - If the accepted beat's addr == NPIX-1: wr_addr <= 0 and the next state is PENDING.
  - An accepted wr_sof mid-frame discards progress; a write to address 0 is not an error.
  - wr_valid = 0: no write, wr_addr holds.
- State PENDING (wr_ready = 0): the back buffer is complete and waits for a swap.
- frame_end = (scan_x == WIDTH-1) & (scan_y == DEPTH-1), evaluated combinationally, acted on at the dclk edge.
- frame_end in PENDING:
  - Front select toggles, swap_pulse = 1 for the following cycle, state -> FILL, wr_ready = 1 the next cycle.
  - The old front becomes the new back; its contents are stale until overwritten.
- frame_end in FILL: no swap; repeat_cnt increments, saturating at 255.
- Simultaneity:
  - A last beat accepted on the same edge as frame_end does not swap on that edge. State becomes PENDING and swaps on the next frame_end.
  - In FILL, frame_end and a write on the same edge are independent.
- Reader:
  - pix_out <= front[scan_y*WIDTH + scan_x] when scan_x < WIDTH and scan_y < DEPTH; otherwise pix_out <= 0.
  - Latency is 1 dclk.
  - Index arithmetic is done at 20-bit width (no truncation before the range check).
- Swap/read ordering: the read on the frame_end edge uses the old front. The read for the next scan (0,0) uses the new front, so there is no mixed frame.
- A write never targets the front buffer.
- Reset mid-fill or in PENDING returns everything to the reset values. The partially written frame is lost.

Test Plan:
- Reset, then 81 beats with wr_valid=1, pattern pixel = (i%5==0), wr_sof on beat 0 -> wr_ready drops on the cycle after beat 80 and fill_state=1. Scan to (8,8) -> swap_pulse one cycle. The next scan of (0,0), (5,0), (1,0) gives pix_out 1, 1, 0, each one cycle later.
- No writes, run 3 full scans -> no swap_pulse, repeat_cnt = 3, pix_out always 0. Force 300 frames -> repeat_cnt holds at 255.
- Write 40 beats, then an accepted wr_sof beat with pixel=1, then 80 more beats -> PENDING after the 81st beat since sof. After the swap, pixel 0 = 1 and the first 40-beat data is gone.
- Accept the last beat (addr 80) on the same edge as frame_end -> no swap that edge. The swap occurs at the next frame_end, and wr_ready stays 0 in between.
- Toggle wr_valid randomly during a fill -> exactly 81 accepted beats, with content matching the accepted sequence. Scan (9,0) and (0,9) -> pix_out = 0.
- Assert clr mid-fill (beat 30) and in PENDING -> all outputs at reset values immediately; next frame reads 0 everywhere; wr_ready = 1 after release.

Source files
------------

// File: rtl/edge_fb_ctrl.sv
// Double-buffered 1-bit edge bitmap between the edge-detector writer and VGA scan reader.
// The back buffer fills in raster order; buffers swap only at a display frame boundary.
module edge_fb_ctrl #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 9,
  parameter int AW    = 7
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_pixel,
  input  logic       wr_sof,
  input  logic [9:0] scan_x,
  input  logic [9:0] scan_y,
  output logic       pix_out,
  output logic       swap_pulse,
  output logic       fill_state,
  output logic [7:0] repeat_cnt
);

  localparam int NPIX = WIDTH * DEPTH;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  // Writer handshake: a beat transfers on a rising dclk when wr_valid && wr_ready.
  // wr_ready depends only on state, never on wr_valid.
  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic [7:0]        repeat_cnt_q, repeat_cnt_d;
  logic              pix_out_q, pix_out_d;
  logic [NPIX-1:0]   buf_q [2];
  logic [NPIX-1:0]   buf_d [2];

  logic [AW-1:0]     beat_addr;
  logic              back_sel;
  logic              frame_end;
  logic              in_range;
  logic [19:0]       rd_lin;

  assign frame_end = (scan_x == 10'(WIDTH - 1)) && (scan_y == 10'(DEPTH - 1));
  assign back_sel  = ~front_sel_q;
  assign beat_addr = wr_sof ? '0 : wr_addr_q;

  // Full 20-bit index so out-of-range coordinates cannot alias into the bitmap.
  assign rd_lin   = 20'(scan_y) * 20'(WIDTH) + 20'(scan_x);
  assign in_range = (scan_x < 10'(WIDTH)) && (scan_y < 10'(DEPTH));

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    front_sel_d  = front_sel_q;
    swap_pulse_d = 1'b0;
    repeat_cnt_d = repeat_cnt_q;
    buf_d        = buf_q;
    wr_ready     = (state_q == FILL);
    pix_out_d    = in_range ? buf_q[front_sel_q][rd_lin[IW-1:0]] : 1'b0;

    case (state_q)
      FILL: begin
        if (wr_valid) begin
          buf_d[back_sel][beat_addr[IW-1:0]] = wr_pixel;
          if (beat_addr == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = PENDING;
          end else begin
            wr_addr_d = beat_addr + AW'(1);
          end
        end
        // Frame boundary with no complete frame: the current front is shown again.
        if (frame_end && (repeat_cnt_q != 8'hFF)) begin
          repeat_cnt_d = repeat_cnt_q + 8'd1;
        end
      end
      PENDING: begin
        if (frame_end) begin
          front_sel_d  = ~front_sel_q;
          swap_pulse_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q      <= FILL;
      wr_addr_q    <= '0;
      front_sel_q  <= 1'b0;
      swap_pulse_q <= 1'b0;
      repeat_cnt_q <= 8'd0;
      pix_out_q    <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      front_sel_q  <= front_sel_d;
      swap_pulse_q <= swap_pulse_d;
      repeat_cnt_q <= repeat_cnt_d;
      pix_out_q    <= pix_out_d;
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
    end
  end

  assign pix_out    = pix_out_q;
  assign swap_pulse = swap_pulse_q;
  assign fill_state = (state_q == PENDING);
  assign repeat_cnt = repeat_cnt_q;

endmodule

// File: tb/tb_edge_fb_ctrl.sv
// Directed and randomized bench for edge_fb_ctrl against a frame-level reference model.
module tb_edge_fb_ctrl;

  logic       dclk = 1'b0;
  logic       clr;
  logic       wr_valid, wr_ready, wr_pixel, wr_sof;
  logic [9:0] scan_x, scan_y;
  logic       pix_out, swap_pulse, fill_state;
  logic [7:0] repeat_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model: two whole frames, the pixels gathered since the last sof, and counters.
  logic [80:0] m_frame [2];
  int          m_front;
  bit          m_pend;
  int          m_rep;
  bit          fill_q [$];
  int          acc;

  edge_fb_ctrl dut (
    .dclk(dclk), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pixel(wr_pixel), .wr_sof(wr_sof),
    .scan_x(scan_x), .scan_y(scan_y),
    .pix_out(pix_out), .swap_pulse(swap_pulse), .fill_state(fill_state),
    .repeat_cnt(repeat_cnt)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_frame[0] = '0;
    m_frame[1] = '0;
    m_front    = 0;
    m_pend     = 1'b0;
    m_rep      = 0;
    fill_q.delete();
  endtask

  // Called at posedge+1; applies inputs, advances the model one edge, checks after the edge.
  task automatic tick(input logic v, input logic p, input logic s, input int x, input int y);
    bit fe, exp_pix, exp_swap;
    wr_valid = v; wr_pixel = p; wr_sof = s;
    scan_x = 10'(x); scan_y = 10'(y);
    #1;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, !m_pend});
    if (v && wr_ready) acc++;
    fe       = (x == 8) && (y == 8);
    exp_pix  = (x < 9 && y < 9) ? m_frame[m_front][y*9 + x] : 1'b0;
    exp_swap = m_pend && fe;
    if (!m_pend) begin
      if (fe && m_rep < 255) m_rep++;
      if (v) begin
        if (s) fill_q.delete();
        fill_q.push_back(p);
        if (fill_q.size() == 81) begin
          for (int k = 0; k < 81; k++) m_frame[1 - m_front][k] = fill_q[k];
          fill_q.delete();
          m_pend = 1'b1;
        end
      end
    end else if (fe) begin
      m_front = 1 - m_front;
      m_pend  = 1'b0;
    end
    @(posedge dclk); #1;
    chk("pix_out", {31'd0, pix_out}, {31'd0, exp_pix});
    chk("swap_pulse", {31'd0, swap_pulse}, {31'd0, exp_swap});
    chk("fill_state", {31'd0, fill_state}, {31'd0, m_pend});
    chk("repeat_cnt", {24'd0, repeat_cnt}, 32'(m_rep));
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; wr_pixel = 1'b0; wr_sof = 1'b0;
    scan_x = 10'd9; scan_y = 10'd9;
    clr = 1'b1;
    #1;
    chk("rst_pix", {31'd0, pix_out}, 32'd0);
    chk("rst_swap", {31'd0, swap_pulse}, 32'd0);
    chk("rst_state", {31'd0, fill_state}, 32'd0);
    chk("rst_rep", {24'd0, repeat_cnt}, 32'd0);
    @(negedge dclk);
    clr = 1'b0;
    model_reset();
    acc = 0;
    @(posedge dclk); #1;
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic scan_frame();
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++)
        tick(1'b0, 1'b0, 1'b0, x, y);
  endtask

  initial begin
    clr = 1'b1;
    wr_valid = 1'b0; wr_pixel = 1'b0; wr_sof = 1'b0;
    scan_x = 10'd9; scan_y = 10'd9;
    model_reset();
    acc = 0;
    repeat (2) @(posedge dclk);
    #1;

    // 1: pattern frame, swap at (8,8), then read back known pixels.
    do_reset();
    for (int i = 0; i < 81; i++) tick(1'b1, (i % 5 == 0), (i == 0), 9, 9);
    chk("t1_ready_drop", {31'd0, wr_ready}, 32'd0);
    chk("t1_pending", {31'd0, fill_state}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8, 8);
    chk("t1_swap", {31'd0, swap_pulse}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 0, 0);
    chk("t1_pix00", {31'd0, pix_out}, 32'd1);
    chk("t1_swap_once", {31'd0, swap_pulse}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 5, 0);
    chk("t1_pix50", {31'd0, pix_out}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1, 0);
    chk("t1_pix10", {31'd0, pix_out}, 32'd0);
    scan_frame();

    // 2: repeat counting and saturation.
    do_reset();
    for (int f = 0; f < 3; f++) scan_frame();
    chk("t2_rep3", {24'd0, repeat_cnt}, 32'd3);
    for (int f = 0; f < 300; f++) tick(1'b0, 1'b0, 1'b0, 8, 8);
    chk("t2_rep_sat", {24'd0, repeat_cnt}, 32'd255);

    // 3: mid-frame sof discards progress.
    do_reset();
    for (int i = 0; i < 40; i++) tick(1'b1, 1'($urandom_range(0, 1)), (i == 0), 9, 9);
    tick(1'b1, 1'b1, 1'b1, 9, 9);
    for (int i = 0; i < 79; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 9, 9);
    chk("t3_not_yet", {31'd0, fill_state}, 32'd0);
    tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 9, 9);
    chk("t3_pending", {31'd0, fill_state}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8, 8);
    tick(1'b0, 1'b0, 1'b0, 0, 0);
    chk("t3_pix0", {31'd0, pix_out}, 32'd1);
    scan_frame();

    // 4: last beat on the frame_end edge defers the swap.
    do_reset();
    for (int i = 0; i < 80; i++) tick(1'b1, 1'($urandom_range(0, 1)), (i == 0), 9, 9);
    tick(1'b1, 1'b1, 1'b0, 8, 8);
    chk("t4_no_swap", {31'd0, swap_pulse}, 32'd0);
    chk("t4_pending", {31'd0, fill_state}, 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 9));
    tick(1'b0, 1'b0, 1'b0, 8, 8);
    chk("t4_swap", {31'd0, swap_pulse}, 32'd1);
    scan_frame();

    // 5: random valid gaps, random pixels and scan positions.
    do_reset();
    for (int n = 0; n < 2000 && !m_pend; n++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (acc == 0),
           $urandom_range(0, 9), $urandom_range(0, 9));
    chk("t5_accepted", 32'(acc), 32'd81);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 9, 9);
    chk("t5_no_extra", 32'(acc), 32'd81);
    tick(1'b0, 1'b0, 1'b0, 8, 8);
    scan_frame();
    tick(1'b0, 1'b0, 1'b0, 9, 0);
    chk("t5_x9", {31'd0, pix_out}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 9);
    chk("t5_y9", {31'd0, pix_out}, 32'd0);

    // 6: reset mid-fill and in PENDING.
    do_reset();
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, (i == 0), 9, 9);
    #2;
    do_reset();
    for (int i = 0; i < 81; i++) tick(1'b1, 1'b1, (i == 0), 9, 9);
    chk("t6_pending", {31'd0, fill_state}, 32'd1);
    #2;
    do_reset();
    scan_frame();
    tick(1'b0, 1'b0, 1'b0, 4, 4);
    chk("t6_cleared", {31'd0, pix_out}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
